// File: rtl/spi_txn_sequencer_pkg.sv
// Shared definitions for the SPI transaction sequencer: FSM state
// encodings, default slave-select gap and command length width.
package spi_txn_sequencer_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SS_SETUP  = 3'd1;
    localparam logic [2:0] ST_LAUNCH    = 3'd2;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_SS_HOLD   = 3'd5;

    localparam int SS_GAP_DEF = 2;
    localparam int CMD_LEN_W  = 4;

endpackage

// File: rtl/spi_txn_sequencer_fifo.sv
// Synchronous FIFO with registered count; push while full is accepted
// only together with a pop. dout reads 0 while empty.
// Ports: clk, reset (sync, active-low), wr/din/full, rd/dout/empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign do_rd = rd && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign do_wr = wr && (!full || do_rd);
    assign dout  = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + 1'b1;
            end
            if (do_rd) begin
                rptr <= rptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (do_rd && !do_wr) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Frames cmd_len host bytes under one spi_ss assignment, handshaking each
// byte with the byte-level SPI master and collecting replies in an RX FIFO.
// Ports: host TX/RX FIFO access, cmd_start/cmd_len/cmd_ready/txn_done,
// master side spi_enable/spi_tx_data/spi_clk_div/spi_ss/spi_busy/spi_rx_data.
module spi_txn_sequencer
    import spi_txn_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SS_GAP     = SS_GAP_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           clk_div_cfg,
    input  logic                 tx_wr,
    input  logic [7:0]           tx_data,
    output logic                 tx_full,
    input  logic                 rx_rd,
    output logic [7:0]           rx_data,
    output logic                 rx_empty,
    input  logic                 cmd_start,
    input  logic [CMD_LEN_W-1:0] cmd_len,
    output logic                 cmd_ready,
    output logic                 txn_done,
    output logic                 spi_enable,
    output logic [7:0]           spi_tx_data,
    output logic [7:0]           spi_clk_div,
    output logic                 spi_ss,
    input  logic                 spi_busy,
    input  logic [7:0]           spi_rx_data
);
    localparam int GAP_W = $clog2(SS_GAP) + 1;
    // spi_enable is registered, so the LAUNCH cycle itself is the last
    // setup cycle; SS_SETUP covers the remaining SS_GAP-1 cycles.
    localparam logic [GAP_W-1:0] SETUP_LOAD =
        GAP_W'((SS_GAP > 1) ? SS_GAP - 2 : 0);
    localparam logic [GAP_W-1:0] HOLD_LOAD = GAP_W'(SS_GAP - 1);
    localparam logic [2:0] FIRST_ST =
        (SS_GAP > 1) ? ST_SS_SETUP : ST_LAUNCH;

    logic [2:0]           state;
    logic [GAP_W-1:0]     gap_cnt;
    logic [CMD_LEN_W-1:0] remaining;
    logic [7:0]           tx_head;
    logic                 tx_empty;
    logic                 rx_full;
    logic                 launch;
    logic                 rx_push;

    assign launch    = (state == ST_LAUNCH) && !tx_empty && !rx_full;
    assign rx_push   = (state == ST_WAIT_DONE) && !spi_busy;
    assign cmd_ready = (state == ST_IDLE) && !txn_done;
    // Deselect as soon as reset is asserted, not one edge later.
    assign spi_ss    = (state == ST_IDLE) || !reset;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (tx_wr),
        .din   (tx_data),
        .full  (tx_full),
        .rd    (launch),
        .dout  (tx_head),
        .empty (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (rx_push),
        .din   (spi_rx_data),
        .full  (rx_full),
        .rd    (rx_rd),
        .dout  (rx_data),
        .empty (rx_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            gap_cnt     <= '0;
            remaining   <= '0;
            spi_enable  <= 1'b0;
            spi_tx_data <= '0;
            spi_clk_div <= '0;
            txn_done    <= 1'b0;
        end else begin
            spi_enable <= 1'b0;
            txn_done   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cmd_start && cmd_ready && cmd_len != '0) begin
                        remaining   <= cmd_len;
                        spi_clk_div <= clk_div_cfg;
                        gap_cnt     <= SETUP_LOAD;
                        state       <= FIRST_ST;
                    end
                end
                ST_SS_SETUP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_LAUNCH;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    if (launch) begin
                        spi_enable  <= 1'b1;
                        spi_tx_data <= tx_head;
                        state       <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (spi_busy) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!spi_busy) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == CMD_LEN_W'(1)) begin
                            gap_cnt <= HOLD_LOAD;
                            state   <= ST_SS_HOLD;
                        end else begin
                            state <= ST_LAUNCH;
                        end
                    end
                end
                ST_SS_HOLD: begin
                    if (gap_cnt == '0) begin
                        txn_done <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_txn_sequencer.md
# spi_txn_sequencer

Multi-byte SPI transaction sequencer that sits directly upstream of the byte-level SPI master. It buffers host bytes in a TX FIFO and frames a transaction of N bytes under one slave-select assertion. It launches each byte into the SPI master with an enable/busy handshake and collects each received byte into an RX FIFO for the host.

## Interface
- FIFO_DEPTH, 4, entries in each of TX and RX FIFO (power of two, ≥2)
- SS_GAP, 2, clk cycles of spi_ss setup before first byte and hold after last byte (≥1)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low; one clock, reset is synchronous and active-low
- clk_div_cfg  in  8  SCLK divider, passed through to master
- tx_wr  in  1  push tx_data into TX FIFO
- tx_data  in  8  host byte to transmit
- tx_full  out  1  TX FIFO full
- rx_rd  in  1  pop RX FIFO
- rx_data  out  8  head of RX FIFO (valid when !rx_empty)
- rx_empty  out  1  RX FIFO empty
- cmd_start  in  1  begin transaction of cmd_len bytes
- cmd_len  in  4  byte count, 1..15; 0 ignored
- cmd_ready  out  1  sequencer idle, cmd_start accepted
- txn_done  out  1  one-cycle pulse at end of transaction
- spi_enable  out  1  one-cycle start pulse to master
- spi_tx_data  out  8  byte presented to master, stable from pulse to done
- spi_clk_div  out  8  registered copy of clk_div_cfg, latched at cmd_start
- spi_ss  out  1  slave select, active-low
- spi_busy  in  1  master transferring
- spi_rx_data  in  8  byte received by master, valid when spi_busy falls

## Operation
- Reset values: tx_full 0, rx_empty 1, rx_data 0, cmd_ready 1, txn_done 0, spi_enable 0, spi_tx_data 0, spi_clk_div 0, spi_ss 1. Both FIFOs are emptied; the FSM goes to IDLE.
- FSM states: IDLE, SS_SETUP, LAUNCH, WAIT_BUSY, WAIT_DONE, SS_HOLD.
- IDLE: cmd_ready=1. On cmd_start with cmd_len≠0: latch len into remaining counter, latch clk_div_cfg, and go to SS_SETUP. cmd_len=0 is ignored and gives no txn_done.
- SS_SETUP: spi_ss=0. Count SS_GAP cycles, then go to LAUNCH.
- LAUNCH: wait until TX FIFO is non-empty AND RX FIFO is not full. That cycle: pop TX into spi_tx_data, pulse spi_enable, go to WAIT_BUSY. spi_ss stays 0 while stalled.
- WAIT_BUSY: wait for spi_busy=1, then go to WAIT_DONE.
- WAIT_DONE: on spi_busy=0, push spi_rx_data into RX and decrement remaining. If remaining becomes 0, go to SS_HOLD; otherwise go to LAUNCH.
- SS_HOLD: spi_ss=0 for SS_GAP cycles. Then spi_ss=1, pulse txn_done, go to IDLE.
- cmd_start outside IDLE is ignored.
- The LAUNCH gate guarantees an RX slot exists, so received bytes are never dropped.
- tx_wr when full is ignored and FIFO contents are unchanged. rx_rd when empty is ignored.
- Simultaneous push and pop on the same FIFO in one cycle is legal and count is unchanged. This includes push when full together with pop, which is accepted.
- FIFO pointers wrap modulo FIFO_DEPTH. The count register is log2(FIFO_DEPTH)+1 bits wide.
- Reset mid-transaction: all state returns to reset values next edge, spi_ss=1 immediately, and no txn_done is produced.

## Timing
- cmd_start at edge k: spi_ss=0 from k+1.
- First spi_enable at k+1+SS_GAP if TX is non-empty and RX has room.
- spi_enable is high for exactly one cycle per byte. Exactly cmd_len pulses occur per transaction.
- Minimum gap between bytes: 1 cycle (WAIT_DONE → LAUNCH).
- RX push is registered; the byte is visible at rx_data one cycle after spi_busy falls (if the FIFO was empty).
- txn_done is asserted in the same cycle spi_ss returns to 1. cmd_ready is 1 on the following cycle.
- FIFO flags are registered-consistent: tx_full and rx_empty reflect state after the current edge.

## Structure
- Shared package: FSM state encodings (3-bit localparams), SS_GAP default, and the cmd_len width constant.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH; ports clk, reset, wr, din, full, rd, dout, empty). It is instantiated twice, for TX and RX.

## Test plan
- Reset: hold reset=0 for 3 cycles with tx_wr pulsing → spi_ss=1, rx_empty=1, tx_full=0, cmd_ready=1, and no FIFO writes take effect.
- Basic 3-byte transaction: write A5, 3C, FF; cmd_start len=3; slave model returns 11, 22, 33 → exactly 3 spi_enable pulses carrying A5, 3C, FF; spi_ss low throughout; txn_done once; rx_data pops give 11, 22, 33.
- TX underrun: cmd_start len=2 with one byte queued → after byte 1, sequencer stalls in LAUNCH with spi_ss=0; writing the second byte 10 cycles later resumes; txn_done after byte 2.
- RX backpressure: FIFO_DEPTH=4, len=6, host does not read → after 4 bytes there are no further spi_enable pulses; popping one RX entry lets exactly one more byte launch.
- Edge commands: cmd_len=0 → no state change and no txn_done. cmd_start during active transaction → ignored, byte count unchanged. Write to full TX FIFO → 5th byte dropped.
- Reset mid-transaction: reset asserted in WAIT_DONE → spi_ss=1 next edge, FIFOs empty, no txn_done, and a new transaction afterwards completes normally.
